ysyx_axi_slave_sram: RTL and testbench
======================================

Name: ysyx_axi_slave_sram

Overview:
- AXI4 slave endpoint that replaces the tied-off slave port of the ysyx top wrapper.
- Services external AXI reads and writes, including bursts, into one single-port synchronous SRAM macro of the io_sramN type (active-low controls, wider than the AXI bus).
- Width, ID, depth and bus/SRAM ratio are parametrised.
- Handles FIXED/INCR/WRAP bursts, narrow transfers, protocol-error responses and fair read/write arbitration.

Parameters:
- DATA_W, 64, AXI data width in bits (power of 2, ≥32).
- ADDR_W, 32, AXI address width.
- ID_W, 4, AXI ID width.
- SRAM_DW, 128, SRAM word width; must equal DATA_W·2^k with k≥0.
- SRAM_AW, 6, SRAM word-address width; depth is 2^SRAM_AW.

Ports:
- clock  in  1  sole clock
- reset  in  1  asynchronous reset, active-high
- slave_awready out 1; slave_awvalid in 1; slave_awaddr in ADDR_W; slave_awid in ID_W; slave_awlen in 8; slave_awsize in 3; slave_awburst in 2  (write address channel)
- slave_wready out 1; slave_wvalid in 1; slave_wdata in DATA_W; slave_wstrb in DATA_W/8; slave_wlast in 1  (write data channel)
- slave_bready in 1; slave_bvalid out 1; slave_bresp out 2; slave_bid out ID_W  (write response channel)
- slave_arready out 1; slave_arvalid in 1; slave_araddr in ADDR_W; slave_arid in ID_W; slave_arlen in 8; slave_arsize in 3; slave_arburst in 2  (read address channel)
- slave_rready in 1; slave_rvalid out 1; slave_rresp out 2; slave_rdata out DATA_W; slave_rlast out 1; slave_rid out ID_W  (read data channel)
- sram_addr out SRAM_AW; sram_cen out 1 (low = enable); sram_wen out 1 (low = write); sram_wmask out SRAM_DW (per bit, low = write bit); sram_wdata out SRAM_DW; sram_rdata in SRAM_DW

Behaviour:
- Clock and reset: one clock, `clock`. `reset` is asynchronous and active-high.
- Reset values: all ready/valid outputs 0, resp/id/rdata/rlast 0, sram_cen=1, sram_wen=1, sram_wmask all 1s, sram_addr/wdata 0. FSM goes to IDLE, arbitration priority goes to read.
- Reset asserted mid-burst: immediate return to IDLE. The in-flight transaction is dropped with no response, and no further SRAM access occurs.
- Address map: OB = log2(SRAM_DW/8), LB = log2(DATA_W/8).
  - Word index = addr[OB+SRAM_AW-1:OB].
  - Lane = addr[OB-1:LB]; zero-width when SRAM_DW = DATA_W.
  - Upper bits are ignored (aliasing); decode is done externally.
- FSM states: IDLE, RD_REQ, RD_DATA, WR_DATA, WR_MEM, WR_RESP.
- IDLE:
  - arready = awready = 1 only in IDLE, gated by arbitration.
  - Only one valid present: grant it.
  - Both valid: grant the side holding priority, then toggle priority (alternating).
  - Address, id, len, size and burst are registered at the handshake. Beat counter is cleared.
- Read path (AR handshake in cycle t):
  - t+1, RD_REQ: cen=0, wen=1, addr=word.
  - t+2, RD_DATA: rvalid=1. rdata = sram_rdata lane selected by the registered lane; the SRAM is idle, so its output is stable. rid = registered id. rlast=1 on beat len.
  - On rvalid & rready: advance address, go to RD_REQ, or to IDLE after the last beat.
  - Sustained rate is one beat per 2 cycles. rvalid holds with stable data until accepted.
- Write path (AW handshake in cycle t):
  - t+1, WR_DATA: wready=1.
  - On wvalid & wready: capture wdata/wstrb, go to WR_MEM.
  - WR_MEM (one cycle): cen=0, wen=0, addr=word. wdata = captured data replicated to every lane. wmask is all 1s except the bits of bytes in the selected lane whose strobe is 1, which are 0.
  - After WR_MEM: WR_DATA, or WR_RESP after beat len.
  - WR_RESP: bvalid=1 with bid and bresp; held until bready, then IDLE.
- Burst addressing (step = 2^size):
  - FIXED: address constant.
  - INCR: address += step.
  - WRAP: legal only for len ∈ {1,3,7,15}. Wraps within an aligned (len+1)·step window.
  - The first beat uses the unaligned address. Later INCR beats are aligned to size.
- Errors, response SLVERR (2'b10):
  - size > LB: no SRAM access for the whole burst. Reads return rdata=0. All beats are still handshaken.
  - burst = 2'b11, or WRAP with an illegal len: treated as INCR, SLVERR.
  - Write with wlast ≠ (beat==len): SLVERR is sticky for the burst. Burst length is governed by awlen, not wlast.
  - Otherwise the response is OKAY (2'b00). For reads, rresp is per beat and equals the burst's error status.
- Counter: 8-bit beat counter; len=255 (256 beats) must complete.

Test Plan:
- Single INCR read, len 0, size 3, araddr 0x48, SRAM word 4 = {0xBBBB…(hi), 0xAAAA…(lo)}: sram_addr=4, cen low in cycle t+1, rdata=0xBBBB_BBBB_BBBB_BBBB, rlast=1, rresp=0 at t+2.
- INCR write, len 3, size 3, awaddr 0x40: SRAM writes go to word/lane 4/0, 4/1, 5/0, 5/1. Beat 1 wstrb=0x0F gives wmask bits [95:64]=0, all other bits 1. Then bvalid with bid = awid and bresp=0.
- WRAP read, len 3, size 3, araddr 0x58: beat addresses 0x58, 0x40, 0x48, 0x50 (words 5, 4, 4, 5). rlast only on the 4th beat.
- arvalid and awvalid high together from reset: read granted first, then the write, then the read again (alternation). rready held low 5 cycles: rvalid and rdata stay stable, no extra SRAM access.
- Error cases:
  - arsize=4 with len 1: two beats, rdata=0, rresp=2'b10, no cen activity.
  - Write with wlast on beat 0 of len 1: both beats written, bresp=2'b10.
- Reset asserted in WR_DATA of a len-7 burst: next cycle all outputs are at reset values, no bvalid. A fresh write after reset completes normally.

Source files
------------

// File: rtl/ysyx_axi_slave_sram.sv
// AXI4 slave endpoint backed by one single-port synchronous io_sramN macro.
// Supports FIXED/INCR/WRAP bursts, narrow transfers, SLVERR reporting and alternating R/W arbitration.
module ysyx_axi_slave_sram #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned ID_W    = 4,
  parameter int unsigned SRAM_DW = 128,
  parameter int unsigned SRAM_AW = 6
) (
  input  logic                  clock,
  input  logic                  reset,

  output logic                  slave_awready,
  input  logic                  slave_awvalid,
  input  logic [ADDR_W-1:0]     slave_awaddr,
  input  logic [ID_W-1:0]       slave_awid,
  input  logic [7:0]            slave_awlen,
  input  logic [2:0]            slave_awsize,
  input  logic [1:0]            slave_awburst,

  output logic                  slave_wready,
  input  logic                  slave_wvalid,
  input  logic [DATA_W-1:0]     slave_wdata,
  input  logic [DATA_W/8-1:0]   slave_wstrb,
  input  logic                  slave_wlast,

  input  logic                  slave_bready,
  output logic                  slave_bvalid,
  output logic [1:0]            slave_bresp,
  output logic [ID_W-1:0]       slave_bid,

  output logic                  slave_arready,
  input  logic                  slave_arvalid,
  input  logic [ADDR_W-1:0]     slave_araddr,
  input  logic [ID_W-1:0]       slave_arid,
  input  logic [7:0]            slave_arlen,
  input  logic [2:0]            slave_arsize,
  input  logic [1:0]            slave_arburst,

  input  logic                  slave_rready,
  output logic                  slave_rvalid,
  output logic [1:0]            slave_rresp,
  output logic [DATA_W-1:0]     slave_rdata,
  output logic                  slave_rlast,
  output logic [ID_W-1:0]       slave_rid,

  output logic [SRAM_AW-1:0]    sram_addr,
  output logic                  sram_cen,
  output logic                  sram_wen,
  output logic [SRAM_DW-1:0]    sram_wmask,
  output logic [SRAM_DW-1:0]    sram_wdata,
  input  logic [SRAM_DW-1:0]    sram_rdata
);

  localparam int unsigned OB     = $clog2(SRAM_DW / 8);
  localparam int unsigned LB     = $clog2(DATA_W / 8);
  localparam int unsigned LANES  = SRAM_DW / DATA_W;
  localparam int unsigned SB     = DATA_W / 8;
  localparam int unsigned LIDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [2:0]  LB3    = 3'(LB);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_DATA, WR_DATA, WR_MEM, WR_RESP
  } state_t;

  state_t              state;
  logic                prio_rd;
  logic [ADDR_W-1:0]   addr_q;
  logic [ID_W-1:0]     id_q;
  logic [7:0]          len_q;
  logic [2:0]          size_q;
  logic [1:0]          burst_q;
  logic [7:0]          beat_q;
  logic                err_q;
  logic                noacc_q;

  function automatic logic [SRAM_AW-1:0] word_of(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] s;
    s = a >> OB;
    return s[SRAM_AW-1:0];
  endfunction

  function automatic logic [LIDX_W-1:0] lane_of(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] s;
    s = (a >> LB) & ADDR_W'(LANES - 1);
    return s[LIDX_W-1:0];
  endfunction

  // WRAP keeps the upper bits of the (len+1)*step window and wraps the low ones.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                  input logic [2:0] size,
                                                  input logic [7:0] len,
                                                  input logic [1:0] burst);
    logic [ADDR_W-1:0] step, win, nxt;
    step = ADDR_W'(1) << size;
    win  = step * ADDR_W'({1'b0, len} + 9'd1);
    case (burst)
      2'b00:   nxt = a;
      2'b10:   nxt = (a & ~(win - ADDR_W'(1))) | ((a + step) & (win - ADDR_W'(1)));
      default: nxt = (a & ~(step - ADDR_W'(1))) + step;
    endcase
    return nxt;
  endfunction

  function automatic logic [SRAM_DW-1:0] make_mask(input logic [LIDX_W-1:0] lane,
                                                   input logic [SB-1:0] strb);
    logic [SRAM_DW-1:0] m;
    m = '1;
    for (int unsigned l = 0; l < LANES; l++)
      for (int unsigned j = 0; j < SB; j++)
        if (l == 32'(lane) && strb[j]) m[(l*SB + j)*8 +: 8] = '0;
    return m;
  endfunction

  logic                ar_grant, aw_grant;
  logic [ADDR_W-1:0]   req_addr;
  logic [ID_W-1:0]     req_id;
  logic [7:0]          req_len;
  logic [2:0]          req_size;
  logic [1:0]          req_burst;
  logic [1:0]          req_burst_eff;
  logic                req_noacc, req_err, bad_burst;
  logic [ADDR_W-1:0]   next_a;
  logic [DATA_W-1:0]   rdata_c;

  assign ar_grant      = slave_arvalid && (!slave_awvalid || prio_rd);
  assign aw_grant      = slave_awvalid && (!slave_arvalid || !prio_rd);
  assign slave_arready = (state == IDLE) && ar_grant;
  assign slave_awready = (state == IDLE) && aw_grant;

  always_comb begin
    req_addr  = slave_awaddr;
    req_id    = slave_awid;
    req_len   = slave_awlen;
    req_size  = slave_awsize;
    req_burst = slave_awburst;
    if (ar_grant) begin
      req_addr  = slave_araddr;
      req_id    = slave_arid;
      req_len   = slave_arlen;
      req_size  = slave_arsize;
      req_burst = slave_arburst;
    end
    req_noacc     = req_size > LB3;
    bad_burst     = (req_burst == 2'b11) ||
                    ((req_burst == 2'b10) && !(req_len inside {8'd1, 8'd3, 8'd7, 8'd15}));
    req_burst_eff = bad_burst ? 2'b01 : req_burst;
    req_err       = req_noacc || bad_burst;
  end

  assign next_a = next_addr(addr_q, size_q, len_q, burst_q);

  // The SRAM is idle during RD_DATA, so its output can be forwarded directly.
  always_comb begin
    rdata_c = '0;
    if (state == RD_DATA && !noacc_q)
      rdata_c = sram_rdata[32'(lane_of(addr_q))*DATA_W +: DATA_W];
  end
  assign slave_rdata = rdata_c;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      prio_rd      <= 1'b1;
      addr_q       <= '0;
      id_q         <= '0;
      len_q        <= '0;
      size_q       <= '0;
      burst_q      <= '0;
      beat_q       <= '0;
      err_q        <= 1'b0;
      noacc_q      <= 1'b0;
      slave_wready <= 1'b0;
      slave_bvalid <= 1'b0;
      slave_bresp  <= '0;
      slave_bid    <= '0;
      slave_rvalid <= 1'b0;
      slave_rresp  <= '0;
      slave_rlast  <= 1'b0;
      slave_rid    <= '0;
      sram_addr    <= '0;
      sram_cen     <= 1'b1;
      sram_wen     <= 1'b1;
      sram_wmask   <= '1;
      sram_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ar_grant || aw_grant) begin
            addr_q  <= req_addr;
            id_q    <= req_id;
            len_q   <= req_len;
            size_q  <= req_size;
            burst_q <= req_burst_eff;
            err_q   <= req_err;
            noacc_q <= req_noacc;
            beat_q  <= '0;
            if (slave_arvalid && slave_awvalid) prio_rd <= !prio_rd;
            if (ar_grant) begin
              state     <= RD_REQ;
              sram_cen  <= req_noacc;
              sram_wen  <= 1'b1;
              sram_addr <= word_of(req_addr);
            end else begin
              state        <= WR_DATA;
              slave_wready <= 1'b1;
            end
          end
        end
        RD_REQ: begin
          sram_cen     <= 1'b1;
          slave_rvalid <= 1'b1;
          slave_rlast  <= (beat_q == len_q);
          slave_rresp  <= err_q ? 2'b10 : 2'b00;
          slave_rid    <= id_q;
          state        <= RD_DATA;
        end
        RD_DATA: begin
          if (slave_rready) begin
            slave_rvalid <= 1'b0;
            slave_rlast  <= 1'b0;
            if (beat_q == len_q) begin
              state <= IDLE;
            end else begin
              beat_q    <= beat_q + 8'd1;
              addr_q    <= next_a;
              sram_cen  <= noacc_q;
              sram_addr <= word_of(next_a);
              state     <= RD_REQ;
            end
          end
        end
        WR_DATA: begin
          if (slave_wvalid) begin
            slave_wready <= 1'b0;
            if (slave_wlast != (beat_q == len_q)) err_q <= 1'b1;
            sram_cen   <= noacc_q;
            sram_wen   <= noacc_q;
            sram_addr  <= word_of(addr_q);
            sram_wdata <= {LANES{slave_wdata}};
            sram_wmask <= make_mask(lane_of(addr_q), slave_wstrb);
            state      <= WR_MEM;
          end
        end
        WR_MEM: begin
          sram_cen   <= 1'b1;
          sram_wen   <= 1'b1;
          sram_wmask <= '1;
          if (beat_q == len_q) begin
            slave_bvalid <= 1'b1;
            slave_bid    <= id_q;
            slave_bresp  <= err_q ? 2'b10 : 2'b00;
            state        <= WR_RESP;
          end else begin
            beat_q       <= beat_q + 8'd1;
            addr_q       <= next_a;
            slave_wready <= 1'b1;
            state        <= WR_DATA;
          end
        end
        WR_RESP: begin
          if (slave_bready) begin
            slave_bvalid <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_axi_slave_sram.sv
// Self-checking bench: byte-array reference memory plus closed-form burst address model,
// behavioural io_sramN macro attached to the DUT.
module tb_ysyx_axi_slave_sram;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        awready, awvalid, wready, wvalid, wlast, bready, bvalid;
  logic [31:0] awaddr, araddr;
  logic [3:0]  awid, arid, bid, rid;
  logic [7:0]  awlen, arlen, wstrb;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [63:0] wdata, rdata;
  logic        arready, arvalid, rready, rvalid, rlast;
  logic [5:0]  sram_addr;
  logic        sram_cen, sram_wen;
  logic [127:0] sram_wmask, sram_wdata, sram_rdata;

  ysyx_axi_slave_sram #(.DATA_W(64), .ADDR_W(32), .ID_W(4), .SRAM_DW(128), .SRAM_AW(6)) dut (
    .clock(clock), .reset(reset),
    .slave_awready(awready), .slave_awvalid(awvalid), .slave_awaddr(awaddr), .slave_awid(awid),
    .slave_awlen(awlen), .slave_awsize(awsize), .slave_awburst(awburst),
    .slave_wready(wready), .slave_wvalid(wvalid), .slave_wdata(wdata), .slave_wstrb(wstrb),
    .slave_wlast(wlast),
    .slave_bready(bready), .slave_bvalid(bvalid), .slave_bresp(bresp), .slave_bid(bid),
    .slave_arready(arready), .slave_arvalid(arvalid), .slave_araddr(araddr), .slave_arid(arid),
    .slave_arlen(arlen), .slave_arsize(arsize), .slave_arburst(arburst),
    .slave_rready(rready), .slave_rvalid(rvalid), .slave_rresp(rresp), .slave_rdata(rdata),
    .slave_rlast(rlast), .slave_rid(rid),
    .sram_addr(sram_addr), .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_wmask(sram_wmask),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  // Behavioural SRAM macro: active-low enables, per-bit active-low write mask.
  logic [127:0] mem [0:63];
  logic         tb_clear;
  always @(posedge clock) begin
    if (tb_clear) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else if (!sram_cen) begin
      if (!sram_wen) mem[sram_addr] <= (mem[sram_addr] & sram_wmask) | (sram_wdata & ~sram_wmask);
      else           sram_rdata     <= mem[sram_addr];
    end
  end

  int unsigned access_cnt = 0;
  always @(negedge clock) if (!sram_cen) access_cnt <= access_cnt + 1;

  int tests = 0;
  int fails = 0;
  logic [7:0] ref_mem [0:1023];

  function automatic bit bad_burst_f(input logic [7:0] len, input logic [1:0] burst);
    return (burst == 2'b11) || (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15));
  endfunction

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int n, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] step, win, base;
    logic [1:0]  b;
    step = 32'd1 << size;
    b = bad_burst_f(len, burst) ? 2'b01 : burst;
    if (b == 2'b00) return a;
    if (b == 2'b01) return (n == 0) ? a : (a - (a % step)) + 32'(n) * step;
    win  = (32'(len) + 1) * step;
    base = a - (a % win);
    return base + ((a - base + 32'(n) * step) % win);
  endfunction

  function automatic logic [63:0] ref_lane(input logic [31:0] ba);
    logic [63:0] d;
    int off;
    off = int'(ba % 1024) & ~7;
    for (int j = 0; j < 8; j++) d[j*8 +: 8] = ref_mem[off + j];
    return d;
  endfunction

  task automatic ref_write(input logic [31:0] ba, input logic [63:0] d, input logic [7:0] s);
    int off;
    off = int'(ba % 1024) & ~7;
    for (int j = 0; j < 8; j++) if (s[j]) ref_mem[off + j] = d[j*8 +: 8];
  endtask

  task automatic idle_inputs();
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0; wlast = 0;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input int stall_max);
    bit err, noacc;
    int n, w, stall;
    int unsigned acc0;
    logic [63:0] exp_d, held;
    logic [1:0] exp_r;
    noacc = size > 3;
    err   = noacc || bad_burst_f(len, burst);
    exp_r = err ? 2'b10 : 2'b00;
    acc0  = access_cnt;
    @(negedge clock);
    arvalid = 1; araddr = a; arid = id; arlen = len; arsize = size; arburst = burst;
    #1;
    w = 0;
    while (!arready && w < 100) begin @(negedge clock); #1; w++; end
    tests++;
    if (!arready) begin
      $display("FAIL ar_handshake: arready=%b required 1", arready);
      fails++; arvalid = 0; return;
    end
    @(posedge clock); #1 arvalid = 0;
    for (n = 0; n <= int'(len); n++) begin
      w = 0;
      @(negedge clock);
      while (!rvalid && w < 100) begin @(negedge clock); w++; end
      tests++;
      if (!rvalid) begin
        $display("FAIL r_timeout: beat %0d rvalid=%b required 1", n, rvalid);
        fails++; return;
      end
      exp_d = noacc ? 64'd0 : ref_lane(beat_addr(a, n, len, size, burst));
      held  = rdata;
      stall = $urandom_range(0, stall_max);
      for (int k = 0; k < stall; k++) begin
        @(negedge clock);
        tests++;
        if (rvalid !== 1'b1 || rdata !== held) begin
          $display("FAIL r_hold: rvalid=%b rdata=%h required 1/%h", rvalid, rdata, held);
          fails++;
        end
      end
      tests++;
      if (rdata !== exp_d || rresp !== exp_r || rid !== id || rlast !== (n == int'(len))) begin
        $display("FAIL r_beat%0d: addr=%h got d=%h resp=%b id=%h last=%b, required d=%h resp=%b id=%h last=%b",
                 n, beat_addr(a, n, len, size, burst), rdata, rresp, rid, rlast,
                 exp_d, exp_r, id, (n == int'(len)));
        fails++;
      end
      rready = 1;
      @(posedge clock); #1 rready = 0;
    end
    tests++;
    if (access_cnt - acc0 !== (noacc ? 0 : 32'(len) + 1)) begin
      $display("FAIL r_accesses: got %0d required %0d", access_cnt - acc0, noacc ? 0 : int'(len) + 1);
      fails++;
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input bit early_last,
                          input bit fixed, input logic [63:0] fd);
    bit err, noacc;
    int n, w;
    int unsigned acc0;
    logic [1:0] exp_b;
    noacc = size > 3;
    err   = noacc || bad_burst_f(len, burst) || (early_last && len != 0);
    exp_b = err ? 2'b10 : 2'b00;
    acc0  = access_cnt;
    @(negedge clock);
    awvalid = 1; awaddr = a; awid = id; awlen = len; awsize = size; awburst = burst;
    #1;
    w = 0;
    while (!awready && w < 100) begin @(negedge clock); #1; w++; end
    tests++;
    if (!awready) begin
      $display("FAIL aw_handshake: awready=%b required 1", awready);
      fails++; awvalid = 0; return;
    end
    @(posedge clock); #1 awvalid = 0;
    for (n = 0; n <= int'(len); n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clock);
      @(negedge clock);
      wvalid = 1;
      wdata  = fixed ? fd : {$urandom, $urandom};
      wstrb  = fixed ? 8'hFF : 8'($urandom);
      wlast  = early_last ? (n == 0) : (n == int'(len));
      w = 0;
      while (!wready && w < 100) begin @(negedge clock); w++; end
      tests++;
      if (!wready) begin
        $display("FAIL w_timeout: beat %0d wready=%b required 1", n, wready);
        fails++; wvalid = 0; return;
      end
      @(posedge clock);
      if (!noacc) ref_write(beat_addr(a, n, len, size, burst), wdata, wstrb);
      #1 wvalid = 0; wlast = 0;
    end
    w = 0;
    @(negedge clock);
    while (!bvalid && w < 100) begin @(negedge clock); w++; end
    tests++;
    if (bvalid !== 1'b1 || bresp !== exp_b || bid !== id) begin
      $display("FAIL b_resp: bvalid=%b bresp=%b bid=%h required 1/%b/%h", bvalid, bresp, bid, exp_b, id);
      fails++;
    end
    repeat ($urandom_range(0, 2)) @(negedge clock);
    bready = 1;
    @(posedge clock); #1 bready = 0;
    tests++;
    if (access_cnt - acc0 !== (noacc ? 0 : 32'(len) + 1)) begin
      $display("FAIL w_accesses: got %0d required %0d", access_cnt - acc0, noacc ? 0 : int'(len) + 1);
      fails++;
    end
  endtask

  task automatic test_reset();
    reset = 1;
    @(negedge clock);
    tests++;
    if ({awready, wready, bvalid, arready, rvalid, rlast, bresp, rresp, bid, rid, rdata} !== '0) begin
      $display("FAIL reset_axi: outputs=%h required 0",
               {awready, wready, bvalid, arready, rvalid, rlast, bresp, rresp, bid, rid, rdata});
      fails++;
    end
    tests++;
    if (sram_cen !== 1'b1 || sram_wen !== 1'b1 || sram_wmask !== '1 || sram_addr !== '0 || sram_wdata !== '0) begin
      $display("FAIL reset_sram: cen=%b wen=%b mask=%h addr=%h wdata=%h required 1/1/all-ones/0/0",
               sram_cen, sram_wen, sram_wmask, sram_addr, sram_wdata);
      fails++;
    end
    reset = 0;
    @(negedge clock);
    tests++;
    if (arready !== 1'b0 || awready !== 1'b0 || rvalid !== 1'b0) begin
      $display("FAIL idle_no_valid: arready=%b awready=%b rvalid=%b required 0", arready, awready, rvalid);
      fails++;
    end
  endtask

  task automatic test_single_read();
    int w;
    do_write(32'h40, 4'h1, 8'd0, 3'd3, 2'b01, 0, 1, 64'hAAAA_AAAA_AAAA_AAAA);
    do_write(32'h48, 4'h1, 8'd0, 3'd3, 2'b01, 0, 1, 64'hBBBB_BBBB_BBBB_BBBB);
    @(negedge clock);
    arvalid = 1; araddr = 32'h48; arid = 4'h3; arlen = 0; arsize = 3; arburst = 2'b01;
    #1;
    w = 0;
    while (!arready && w < 100) begin @(negedge clock); #1; w++; end
    @(posedge clock); #1 arvalid = 0;
    @(negedge clock);
    tests++;
    if (sram_cen !== 1'b0 || sram_wen !== 1'b1 || sram_addr !== 6'd4) begin
      $display("FAIL rd_req_cycle: cen=%b wen=%b addr=%0d required 0/1/4", sram_cen, sram_wen, sram_addr);
      fails++;
    end
    @(negedge clock);
    tests++;
    if (rvalid !== 1'b1 || rdata !== 64'hBBBB_BBBB_BBBB_BBBB || rlast !== 1'b1 || rresp !== 2'b00 || rid !== 4'h3) begin
      $display("FAIL rd_data_cycle: rvalid=%b rdata=%h rlast=%b rresp=%b rid=%h required 1/bbbbbbbbbbbbbbbb/1/00/3",
               rvalid, rdata, rlast, rresp, rid);
      fails++;
    end
    rready = 1;
    @(posedge clock); #1 rready = 0;
  endtask

  task automatic test_incr_write();
    int w;
    logic [5:0]   words [4];
    logic [127:0] exp_m;
    words = '{6'd4, 6'd4, 6'd5, 6'd5};
    @(negedge clock);
    awvalid = 1; awaddr = 32'h40; awid = 4'h9; awlen = 3; awsize = 3; awburst = 2'b01;
    #1;
    w = 0;
    while (!awready && w < 100) begin @(negedge clock); #1; w++; end
    @(posedge clock); #1 awvalid = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clock);
      wvalid = 1; wdata = {$urandom, $urandom}; wstrb = (n == 1) ? 8'h0F : 8'hFF; wlast = (n == 3);
      w = 0;
      while (!wready && w < 100) begin @(negedge clock); w++; end
      @(posedge clock);
      ref_write(32'h40 + 32'(n) * 8, wdata, wstrb);
      #1 wvalid = 0;
      exp_m = '1;
      for (int j = 0; j < 8; j++) if (wstrb[j]) exp_m[((n % 2) * 8 + j) * 8 +: 8] = 8'h00;
      @(negedge clock);
      tests++;
      if (sram_cen !== 1'b0 || sram_wen !== 1'b0 || sram_addr !== words[n] ||
          sram_wmask !== exp_m || sram_wdata !== {wdata, wdata}) begin
        $display("FAIL wr_mem_beat%0d: cen=%b wen=%b addr=%0d mask=%h required 0/0/%0d/%h",
                 n, sram_cen, sram_wen, sram_addr, sram_wmask, words[n], exp_m);
        fails++;
      end
    end
    w = 0;
    while (!bvalid && w < 100) begin @(negedge clock); w++; end
    tests++;
    if (bvalid !== 1'b1 || bid !== 4'h9 || bresp !== 2'b00) begin
      $display("FAIL incr_bresp: bvalid=%b bid=%h bresp=%b required 1/9/00", bvalid, bid, bresp);
      fails++;
    end
    bready = 1;
    @(posedge clock); #1 bready = 0;
  endtask

  task automatic test_arbitration();
    int w;
    logic [63:0] held, d;
    int unsigned acc0;
    @(negedge clock);
    arvalid = 1; araddr = 32'h48; arid = 4'h1; arlen = 0; arsize = 3; arburst = 2'b01;
    awvalid = 1; awaddr = 32'h80; awid = 4'h2; awlen = 0; awsize = 3; awburst = 2'b01;
    #1;
    tests++;
    if (arready !== 1'b1 || awready !== 1'b0) begin
      $display("FAIL arb_read_first: arready=%b awready=%b required 1/0", arready, awready);
      fails++;
    end
    @(posedge clock); #1;
    w = 0;
    @(negedge clock);
    while (!rvalid && w < 100) begin @(negedge clock); w++; end
    held = rdata;
    acc0 = access_cnt;
    repeat (5) begin
      @(negedge clock);
      tests++;
      if (rvalid !== 1'b1 || rdata !== held) begin
        $display("FAIL arb_rhold: rvalid=%b rdata=%h required 1/%h", rvalid, rdata, held);
        fails++;
      end
    end
    tests++;
    if (access_cnt !== acc0 || held !== ref_lane(32'h48)) begin
      $display("FAIL arb_stall_data: accesses=%0d rdata=%h required %0d/%h", access_cnt, held, acc0, ref_lane(32'h48));
      fails++;
    end
    rready = 1;
    @(posedge clock); #1 rready = 0;
    tests++;
    if (awready !== 1'b1 || arready !== 1'b0) begin
      $display("FAIL arb_then_write: awready=%b arready=%b required 1/0", awready, arready);
      fails++;
    end
    @(posedge clock); #1 awvalid = 0;
    @(negedge clock);
    d = {$urandom, $urandom};
    wvalid = 1; wdata = d; wstrb = 8'hFF; wlast = 1;
    w = 0;
    while (!wready && w < 100) begin @(negedge clock); w++; end
    @(posedge clock);
    ref_write(32'h80, d, 8'hFF);
    #1 wvalid = 0; wlast = 0;
    w = 0;
    @(negedge clock);
    while (!bvalid && w < 100) begin @(negedge clock); w++; end
    tests++;
    if (bvalid !== 1'b1 || bresp !== 2'b00 || bid !== 4'h2) begin
      $display("FAIL arb_bresp: bvalid=%b bresp=%b bid=%h required 1/00/2", bvalid, bresp, bid);
      fails++;
    end
    awvalid = 1;
    bready = 1;
    @(posedge clock); #1 bready = 0;
    tests++;
    if (arready !== 1'b1 || awready !== 1'b0) begin
      $display("FAIL arb_read_again: arready=%b awready=%b required 1/0", arready, awready);
      fails++;
    end
    araddr = 32'h80;
    #1;
    @(posedge clock); #1 arvalid = 0; awvalid = 0;
    w = 0;
    @(negedge clock);
    while (!rvalid && w < 100) begin @(negedge clock); w++; end
    tests++;
    if (rvalid !== 1'b1 || rdata !== d || rlast !== 1'b1) begin
      $display("FAIL arb_second_read: rvalid=%b rdata=%h rlast=%b required 1/%h/1", rvalid, rdata, rlast, d);
      fails++;
    end
    rready = 1;
    @(posedge clock); #1 rready = 0;
  endtask

  task automatic test_errors();
    do_read(32'h40, 4'h4, 8'd1, 3'd4, 2'b01, 1);
    do_write(32'h40, 4'h6, 8'd1, 3'd3, 2'b01, 1, 0, 64'd0);
    do_read(32'h40, 4'h7, 8'd1, 3'd3, 2'b01, 0);
    do_read(32'h60, 4'h8, 8'd2, 3'd3, 2'b11, 0);
    do_read(32'h60, 4'h8, 8'd2, 3'd3, 2'b10, 0);
  endtask

  task automatic test_reset_mid_burst();
    int w;
    int unsigned acc0;
    @(negedge clock);
    awvalid = 1; awaddr = 32'h100; awid = 4'h5; awlen = 7; awsize = 3; awburst = 2'b01;
    #1;
    w = 0;
    while (!awready && w < 100) begin @(negedge clock); #1; w++; end
    @(posedge clock); #1 awvalid = 0;
    for (int n = 0; n < 2; n++) begin
      @(negedge clock);
      wvalid = 1; wdata = {$urandom, $urandom}; wstrb = 8'hFF; wlast = 0;
      w = 0;
      while (!wready && w < 100) begin @(negedge clock); w++; end
      @(posedge clock);
      ref_write(32'h100 + 32'(n) * 8, wdata, wstrb);
      #1 wvalid = 0;
    end
    w = 0;
    @(negedge clock);
    while (!wready && w < 100) begin @(negedge clock); w++; end
    reset = 1;
    @(posedge clock); #1;
    tests++;
    if ({wready, bvalid, rvalid, awready, arready} !== '0 || sram_cen !== 1'b1 || sram_wen !== 1'b1 ||
        sram_wmask !== '1 || sram_addr !== '0 || sram_wdata !== '0) begin
      $display("FAIL mid_reset_vals: w/b/r/aw/ar=%b cen=%b wen=%b addr=%h required 00000/1/1/0",
               {wready, bvalid, rvalid, awready, arready}, sram_cen, sram_wen, sram_addr);
      fails++;
    end
    @(negedge clock);
    reset = 0;
    acc0 = access_cnt;
    repeat (12) begin
      @(negedge clock);
      tests++;
      if (bvalid !== 1'b0 || wready !== 1'b0) begin
        $display("FAIL mid_reset_quiet: bvalid=%b wready=%b required 0/0", bvalid, wready);
        fails++;
      end
    end
    tests++;
    if (access_cnt !== acc0) begin
      $display("FAIL mid_reset_access: got %0d accesses required 0", access_cnt - acc0);
      fails++;
    end
    do_write(32'h100, 4'hA, 8'd3, 3'd3, 2'b01, 0, 0, 64'd0);
    do_read(32'h100, 4'hA, 8'd7, 3'd3, 2'b01, 1);
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    for (int i = 0; i < 40; i++) begin
      burst = 2'($urandom_range(0, 3));
      size  = ($urandom_range(0, 9) == 0) ? 3'd4 : 3'($urandom_range(0, 3));
      len   = (burst == 2'b10) ? 8'(({$urandom} % 4 == 0) ? 15 : (1 << $urandom_range(1, 3)) - 1)
                               : 8'($urandom_range(0, 7));
      a     = {$urandom_range(0, 7), 22'd0, 10'($urandom)};
      if (burst == 2'b10) a = a & ~((32'd1 << size) - 1);
      if ($urandom_range(0, 1) == 1) do_write(a, 4'($urandom), len, size, burst, 0, 0, 64'd0);
      else                           do_read(a, 4'($urandom), len, size, burst, 2);
    end
  endtask

  task automatic test_long_burst();
    do_write(32'h3F8, 4'hC, 8'd255, 3'd2, 2'b01, 0, 0, 64'd0);
    do_read(32'h0, 4'hD, 8'd255, 3'd3, 2'b01, 0);
  endtask

  initial begin
    idle_inputs();
    awaddr = 0; awid = 0; awlen = 0; awsize = 0; awburst = 0;
    araddr = 0; arid = 0; arlen = 0; arsize = 0; arburst = 0;
    wdata = 0; wstrb = 0;
    reset = 1; tb_clear = 1;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
    repeat (3) @(negedge clock);
    tb_clear = 0;
    test_reset();
    test_arbitration();
    test_single_read();
    test_incr_write();
    do_read(32'h58, 4'hE, 8'd3, 3'd3, 2'b10, 1);
    test_errors();
    test_reset_mid_burst();
    test_random();
    test_long_burst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
